// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - writeback stage: ALU/load results to register file write port
//
// Purpose: accepts completed ALU results and pending loads, waits for the data
// memory response, extends load data and drives the register file write port.
// x0 is never written.
//
// Optional feature macro: WB_BYPASS_EN (adds decode bypass ports).
//
// Ports:
//   clk_i              core clock, rising edge
//   rst_ni             asynchronous active-low reset
//   ex_valid_i         execute presents an instruction
//   ex_ready_o         instruction accepted this cycle (high only in IDLE)
//   ex_reg_we_i        instruction writes rd
//   ex_is_load_i       instruction is a load
//   ex_rd_i            destination register
//   ex_result_i        ALU result (ignored for loads)
//   ex_funct3_i        load width/sign
//   ex_addr_lo_i       load address bits [1:0]
//   dmem_resp_valid_i  load response valid pulse
//   dmem_resp_data_i   aligned word holding the load data
//   we_o               register file write enable
//   wb_addr_o          register file write address
//   wb_data_o          register file write data
//   resp_unexp_o       pulse: response arrived with no load pending
//   rs1_addr_i, rs2_addr_i, rs1_byp_hit_o, rs2_byp_hit_o, byp_data_o
//                      (WB_BYPASS_EN only) same-cycle write forwarding to decode

module wb_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            ex_valid_i,
    output logic            ex_ready_o,
    input  logic            ex_reg_we_i,
    input  logic            ex_is_load_i,
    input  logic [4:0]      ex_rd_i,
    input  logic [XLEN-1:0] ex_result_i,
    input  logic [2:0]      ex_funct3_i,
    input  logic [1:0]      ex_addr_lo_i,
    input  logic            dmem_resp_valid_i,
    input  logic [XLEN-1:0] dmem_resp_data_i,
`ifdef WB_BYPASS_EN
    input  logic [4:0]      rs1_addr_i,
    input  logic [4:0]      rs2_addr_i,
    output logic            rs1_byp_hit_o,
    output logic            rs2_byp_hit_o,
    output logic [XLEN-1:0] byp_data_o,
`endif
    output logic            we_o,
    output logic [4:0]      wb_addr_o,
    output logic [XLEN-1:0] wb_data_o,
    output logic            resp_unexp_o
);

    typedef enum logic {
        IDLE      = 1'b0,
        LOAD_WAIT = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic              we_q, we_d;
    logic [4:0]        wb_addr_q, wb_addr_d;
    logic [XLEN-1:0]   wb_data_q, wb_data_d;
    logic              resp_unexp_q, resp_unexp_d;

    // Load context captured at accept time, used when the response returns.
    logic              cap_we_q, cap_we_d;
    logic [4:0]        cap_rd_q, cap_rd_d;
    logic [2:0]        cap_funct3_q, cap_funct3_d;
    logic [1:0]        cap_addr_lo_q, cap_addr_lo_d;

    logic [XLEN-1:0]   load_data;

    // Select byte/halfword from the aligned word and extend to XLEN.
    function automatic logic [XLEN-1:0] extend_load(
        input logic [XLEN-1:0] data,
        input logic [2:0]      funct3,
        input logic [1:0]      addr_lo
    );
        logic [7:0]  byte_v;
        logic [15:0] half_v;
        case (addr_lo)
            2'd0:    byte_v = data[7:0];
            2'd1:    byte_v = data[15:8];
            2'd2:    byte_v = data[23:16];
            default: byte_v = data[31:24];
        endcase
        half_v = addr_lo[1] ? data[31:16] : data[15:0];
        case (funct3)
            3'b000:  extend_load = {{(XLEN-8){byte_v[7]}}, byte_v};
            3'b100:  extend_load = {{(XLEN-8){1'b0}}, byte_v};
            3'b001:  extend_load = {{(XLEN-16){half_v[15]}}, half_v};
            3'b101:  extend_load = {{(XLEN-16){1'b0}}, half_v};
            default: extend_load = data;
        endcase
    endfunction

    assign load_data  = extend_load(dmem_resp_data_i, cap_funct3_q, cap_addr_lo_q);
    assign ex_ready_o = (state_q == IDLE);

    always_comb begin
        state_d       = state_q;
        we_d          = 1'b0;
        wb_addr_d     = wb_addr_q;
        wb_data_d     = wb_data_q;
        resp_unexp_d  = 1'b0;
        cap_we_d      = cap_we_q;
        cap_rd_d      = cap_rd_q;
        cap_funct3_d  = cap_funct3_q;
        cap_addr_lo_d = cap_addr_lo_q;

        case (state_q)
            IDLE: begin
                // A response with nothing outstanding is dropped, even if a
                // load is being accepted in the same cycle.
                if (dmem_resp_valid_i) begin
                    resp_unexp_d = 1'b1;
                end
                if (ex_valid_i) begin
                    if (ex_is_load_i) begin
                        cap_we_d      = ex_reg_we_i;
                        cap_rd_d      = ex_rd_i;
                        cap_funct3_d  = ex_funct3_i;
                        cap_addr_lo_d = ex_addr_lo_i;
                        state_d       = LOAD_WAIT;
                    end else if (ex_reg_we_i && (ex_rd_i != 5'd0)) begin
                        we_d      = 1'b1;
                        wb_addr_d = ex_rd_i;
                        wb_data_d = ex_result_i;
                    end
                end
            end
            LOAD_WAIT: begin
                if (dmem_resp_valid_i) begin
                    state_d = IDLE;
                    if (cap_we_q && (cap_rd_q != 5'd0)) begin
                        we_d      = 1'b1;
                        wb_addr_d = cap_rd_q;
                        wb_data_d = load_data;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= IDLE;
            we_q          <= 1'b0;
            wb_addr_q     <= 5'd0;
            wb_data_q     <= '0;
            resp_unexp_q  <= 1'b0;
            cap_we_q      <= 1'b0;
            cap_rd_q      <= 5'd0;
            cap_funct3_q  <= 3'd0;
            cap_addr_lo_q <= 2'd0;
        end else begin
            state_q       <= state_d;
            we_q          <= we_d;
            wb_addr_q     <= wb_addr_d;
            wb_data_q     <= wb_data_d;
            resp_unexp_q  <= resp_unexp_d;
            cap_we_q      <= cap_we_d;
            cap_rd_q      <= cap_rd_d;
            cap_funct3_q  <= cap_funct3_d;
            cap_addr_lo_q <= cap_addr_lo_d;
        end
    end

    assign we_o         = we_q;
    assign wb_addr_o    = wb_addr_q;
    assign wb_data_o    = wb_data_q;
    assign resp_unexp_o = resp_unexp_q;

`ifdef WB_BYPASS_EN
    // The register file read returns the pre-write value, so decode looks here.
    assign rs1_byp_hit_o = we_q && (wb_addr_q == rs1_addr_i);
    assign rs2_byp_hit_o = we_q && (wb_addr_q == rs2_addr_i);
    assign byp_data_o    = wb_data_q;
`endif

endmodule

// File: doc/wb_stage.md
# wb_stage

Writeback stage for the five-stage core. Accepts completed ALU results and pending loads from the execute/memory boundary, waits for data-memory load responses, sign- or zero-extends load data, and drives the register file's synchronous write port (`we`, `wb_addr`, `wb_data`). It also guarantees that x0 is never written, because the register file does not hard-wire x0.

## Interface
- `XLEN`, 32, datapath width. Only 32 is supported.
- `clk`  in  1  core clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `ex_valid`  in  1  execute presents an instruction.
- `ex_ready`  out  1  wb_stage accepts it this cycle.
- `ex_reg_we`  in  1  the instruction writes rd.
- `ex_is_load`  in  1  the instruction is a load; its result comes from data memory.
- `ex_rd`  in  5  destination register.
- `ex_result`  in  XLEN  ALU result. Ignored for loads.
- `ex_funct3`  in  3  load width/sign.
- `ex_addr_lo`  in  2  load address bits [1:0].
- `dmem_resp_valid`  in  1  load response valid (single-cycle pulse).
- `dmem_resp_data`  in  XLEN  aligned 32-bit word containing the load data.
- `we`  out  1  register file write enable.
- `wb_addr`  out  5  register file write address.
- `wb_data`  out  XLEN  register file write data.
- `resp_unexp`  out  1  one-cycle pulse: a response arrived while no load was pending.

## Operation
- **States:**
  - IDLE: `ex_ready` = 1.
  - LOAD_WAIT: `ex_ready` = 0. `ex_ready` is decoded purely from the state.
- **Accept:** an instruction is accepted when `ex_valid && ex_ready`.
- **ALU path:**
  - Accept with `ex_is_load` = 0: register `we` = `ex_reg_we && ex_rd != 0`, `wb_addr` = `ex_rd`, `wb_data` = `ex_result`.
  - State stays IDLE.
- **Load path:**
  - Accept with `ex_is_load` = 1: capture `ex_rd`, `ex_reg_we`, `ex_funct3` and `ex_addr_lo`, then go to LOAD_WAIT.
  - In LOAD_WAIT, a cycle with `dmem_resp_valid` registers the write (`we` = captured_we && captured_rd != 0) and returns the state to IDLE.
- **Load extension:**
  - 000 lb: byte `addr_lo`, sign-extended.
  - 100 lbu: byte `addr_lo`, zero-extended.
  - 001 lh: halfword `addr_lo[1]`, sign-extended.
  - 101 lhu: halfword `addr_lo[1]`, zero-extended.
  - 010 and all other codes: the raw word.
  - Byte k is `data[8k+7:8k]`.
- **Unexpected response:** `dmem_resp_valid` in IDLE is dropped without a write, and `resp_unexp` is registered high for one cycle.
- **Non-writing cycles:** when no write is produced, `we` = 0. `wb_addr` and `wb_data` hold their last values.
- **Reset values:** state IDLE, `we` 0, `wb_addr` 0, `wb_data` 0, `resp_unexp` 0, all capture registers 0.
- **Reset during LOAD_WAIT:** the pending load is abandoned. Its late response is treated as unexpected (`resp_unexp` pulses, no write).

## Timing
- **ALU latency:** accepted at the edge ending cycle N; `we` is high during cycle N+1 only, unless another write follows.
- **Back-to-back ALU:** accepts every cycle, one write per cycle, no bubbles.
- **Load latency:** the response is sampled in cycle M (M ≥ N+1); `we` is high in cycle M+1. `ex_ready` is low from N+1 through M and high again in M+1.
- **Next instruction after a load:** a new instruction accepted in M+1 produces its write in M+2. Writes never collide.
- **Response ordering:** a response in the same cycle as the load's acceptance is not possible by protocol. If it occurs, it is unexpected (state is still IDLE).

## Configuration
- `WB_BYPASS_EN`:
  - **Defined:** adds inputs `rs1_addr`, `rs2_addr` (5 bits each) and outputs `rs1_byp_hit`, `rs2_byp_hit` (1 bit) and `byp_data` (XLEN).
    - `rsX_byp_hit` = `we && wb_addr == rsX_addr`, purely combinational.
    - `byp_data` = `wb_data`.
    - Decode uses these to see the value being written this cycle, since the register file read returns the pre-write value.
  - **Undefined:** these ports do not exist.

## Test plan
- **Reset:** `reset` low mid-run → all outputs 0 immediately (asynchronous), state IDLE, `ex_ready` = 1 after release.
- **ALU writes:** ALU `rd`=5, result 0xDEADBEEF, `reg_we`=1 → next cycle `we`=1, `wb_addr`=5, `wb_data`=0xDEADBEEF. The same instruction with `rd`=0 → `we`=0.
- **lb:** load funct3=000, `addr_lo`=2, response 0x0080_0000 after 3 cycles → `ex_ready` low for 3 cycles, then `wb_data`=0xFFFF_FF80, `we` pulses once.
- **lhu / lh:** lhu `addr_lo`=2, response 0x8001_1234 → `wb_data`=0x0000_8001. lh with the same inputs → 0xFFFF_8001. lw → 0x8001_1234.
- **Unexpected response / reset mid-load:** `dmem_resp_valid` while IDLE → `resp_unexp` pulse, `we`=0. Reset asserted in LOAD_WAIT, then a response → no write, `resp_unexp`=1.
- **Bypass (`WB_BYPASS_EN`):** ALU write to x7 with `rs1_addr`=7, `rs2_addr`=8 → `rs1_byp_hit`=1, `rs2_byp_hit`=0, `byp_data`=`wb_data`.
